icache_way_data_array: RTL and testbench

Parametrised, multi-way instruction-cache data store. It is the successor to the single-way 8-set/256-bit line array. It adds way selection, a byte-masked direct write port, and an internal burst-fill engine. The fill engine assembles a line from memory beats and commits it in one cycle. It sits between the icache control FSM, which supplies the index, way, fill start and writes, and the memory-side burst interface.

---
 rtl/icache_way_data_array.sv | 165 ++++++++++++++++
 tb/tb_icache_way_data_array.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_way_data_array.sv
// Multi-way icache line store: combinational bypassed read, byte-masked direct write,
// and a burst-fill engine that gathers NUM_BEATS memory beats and commits the line in one cycle.
module icache_way_data_array #(
   parameter int LINE_W   = 256,
   parameter int BEAT_W   = 64,
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2,
   localparam int IDX_W     = $clog2(NUM_SETS),
   localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   localparam int NUM_BEATS = LINE_W / BEAT_W,
   localparam int MASK_W    = LINE_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [WAY_W-1:0]  rd_way,
   output logic [LINE_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [WAY_W-1:0]  wr_way,
   input  logic [MASK_W-1:0] wr_mask,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              fill_start,
   input  logic [IDX_W-1:0]  fill_index,
   input  logic [WAY_W-1:0]  fill_way,
   input  logic              beat_valid,
   input  logic [BEAT_W-1:0] beat_data,
   output logic              beat_ready,
   output logic              fill_busy,
   output logic              fill_done
);

   localparam int CNT_W = $clog2(NUM_BEATS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_COMMIT  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] buf_q, buf_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WAY_W-1:0]  way_q, way_d;
   logic [LINE_W-1:0] mem_q [NUM_WAYS][NUM_SETS];

   logic beat_acc;
   logic commit_en;
   logic rd_commit_hit;
   logic rd_wr_hit;

   // Shared by the storage update and the read bypass so both always agree:
   // the committed line lands first, then the direct write overrides per byte.
   function automatic logic [LINE_W-1:0] post_edge(
      input logic [LINE_W-1:0] old_line,
      input logic              commit_hit,
      input logic [LINE_W-1:0] fill_line,
      input logic              wr_hit,
      input logic [MASK_W-1:0] mask,
      input logic [LINE_W-1:0] wdata
   );
      logic [LINE_W-1:0] line;
      line = commit_hit ? fill_line : old_line;
      if (wr_hit) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) begin
               line[8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
      return line;
   endfunction

   assign beat_acc  = (state_q == S_COLLECT) && beat_valid;
   assign commit_en = (state_q == S_COMMIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      idx_d      = idx_q;
      way_d      = way_q;
      beat_ready = 1'b0;
      fill_busy  = 1'b0;
      fill_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fill_start) begin
               idx_d   = fill_index;
               way_d   = fill_way;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            beat_ready = 1'b1;
            fill_busy  = 1'b1;
            if (beat_acc) begin
               buf_d[cnt_q*BEAT_W +: BEAT_W] = beat_data;
               if (cnt_q == CNT_W'(NUM_BEATS - 1)) begin
                  cnt_d   = '0;
                  state_d = S_COMMIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COMMIT: begin
            fill_busy = 1'b1;
            fill_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         idx_q   <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         way_q   <= way_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               mem_q[w][s] <= '0;
            end
         end
      end else begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               mem_q[w][s] <= post_edge(
                  mem_q[w][s],
                  commit_en && (idx_q == IDX_W'(s)) && (way_q == WAY_W'(w)),
                  buf_q,
                  wr_en && (wr_index == IDX_W'(s)) && (wr_way == WAY_W'(w)),
                  wr_mask,
                  wr_data);
            end
         end
      end
   end

   assign rd_commit_hit = commit_en && (idx_q == rd_index) && (way_q == rd_way);
   assign rd_wr_hit     = wr_en && (wr_index == rd_index) && (wr_way == rd_way);

   always_comb begin
      rd_data = post_edge(mem_q[rd_way][rd_index], rd_commit_hit, buf_q,
                          rd_wr_hit, wr_mask, wr_data);
   end

endmodule

// File: tb/tb_icache_way_data_array.sv
// Bench for icache_way_data_array: directed scenarios plus random traffic, all checked
// every cycle against a line-level model of the cache contents and fill progress.
module tb_icache_way_data_array;

   localparam int LINE_W   = 256;
   localparam int BEAT_W   = 64;
   localparam int NUM_SETS = 8;
   localparam int NUM_WAYS = 2;
   localparam int IDX_W    = 3;
   localparam int WAY_W    = 1;
   localparam int MASK_W   = 32;
   localparam int NBEATS   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [IDX_W-1:0]  rd_index;
   logic [WAY_W-1:0]  rd_way;
   logic [LINE_W-1:0] rd_data;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_index;
   logic [WAY_W-1:0]  wr_way;
   logic [MASK_W-1:0] wr_mask;
   logic [LINE_W-1:0] wr_data;
   logic              fill_start;
   logic [IDX_W-1:0]  fill_index;
   logic [WAY_W-1:0]  fill_way;
   logic              beat_valid;
   logic [BEAT_W-1:0] beat_data;
   logic              beat_ready;
   logic              fill_busy;
   logic              fill_done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   icache_way_data_array #(
      .LINE_W(LINE_W), .BEAT_W(BEAT_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_index(rd_index), .rd_way(rd_way), .rd_data(rd_data),
      .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_mask(wr_mask), .wr_data(wr_data),
      .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
      .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(beat_ready),
      .fill_busy(fill_busy), .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   // Model: cache contents as a plain 2-D array of lines, plus the fill in progress.
   logic [LINE_W-1:0] m_mem [NUM_WAYS][NUM_SETS];
   logic [LINE_W-1:0] m_line;
   bit                m_collect = 0;
   bit                m_commit  = 0;
   int                m_nb      = 0;
   logic [IDX_W-1:0]  m_idx;
   logic [WAY_W-1:0]  m_way;
   bit                model_valid = 0;

   function automatic logic [LINE_W-1:0] overlay(input logic [LINE_W-1:0] base,
                                                  input logic [LINE_W-1:0] d,
                                                  input logic [MASK_W-1:0] m);
      logic [LINE_W-1:0] r;
      r = base;
      for (int b = 0; b < MASK_W; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         for (int w = 0; w < NUM_WAYS; w++)
            for (int s = 0; s < NUM_SETS; s++) m_mem[w][s] = '0;
         m_collect   = 0;
         m_commit    = 0;
         m_nb        = 0;
         m_line      = '0;
         m_idx       = '0;
         m_way       = '0;
         model_valid = 1;
      end else if (model_valid) begin
         if (m_commit) m_mem[m_way][m_idx] = m_line;
         if (wr_en) m_mem[wr_way][wr_index] = overlay(m_mem[wr_way][wr_index], wr_data, wr_mask);
         if (m_commit) begin
            m_commit = 0;
         end else if (m_collect) begin
            if (beat_valid) begin
               m_line[m_nb*BEAT_W +: BEAT_W] = beat_data;
               m_nb++;
               if (m_nb == NBEATS) begin
                  m_collect = 0;
                  m_commit  = 1;
                  m_nb      = 0;
               end
            end
         end else if (fill_start) begin
            m_collect = 1;
            m_idx     = fill_index;
            m_way     = fill_way;
            m_nb      = 0;
         end
      end
   end

   initial forever begin
      logic [LINE_W-1:0] e;
      @(negedge clk);
      if (model_valid) begin
         e = m_mem[rd_way][rd_index];
         if (m_commit && m_idx == rd_index && m_way == rd_way) e = m_line;
         if (wr_en && wr_index == rd_index && wr_way == rd_way) e = overlay(e, wr_data, wr_mask);
         chk("rd_data", rd_data, e);
         chk("beat_ready", {255'b0, beat_ready}, {255'b0, m_collect});
         chk("fill_busy", {255'b0, fill_busy}, {255'b0, m_collect | m_commit});
         chk("fill_done", {255'b0, fill_done}, {255'b0, m_commit});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int idx, input int way);
      rd_index = IDX_W'(idx);
      rd_way   = WAY_W'(way);
   endtask

   // Leaves the bench just inside the COMMIT cycle with beat_valid low.
   task automatic fill_to_commit(input int idx, input int way, input logic [LINE_W-1:0] line,
                                 input int stall_after, input int stall_cyc, input bit spurious);
      fill_start = 1'b1;
      fill_index = IDX_W'(idx);
      fill_way   = WAY_W'(way);
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < NBEATS; k++) begin
         beat_valid = 1'b1;
         beat_data  = line[k*BEAT_W +: BEAT_W];
         tick();
         beat_valid = 1'b0;
         if (k == stall_after) begin
            for (int c = 0; c < stall_cyc; c++) begin
               if (spurious && c == 1) begin
                  fill_start = 1'b1;
                  fill_index = IDX_W'(2);
               end
               tick();
               fill_start = 1'b0;
            end
         end
      end
   endtask

   task automatic finish_commit();
      chk("done_in_commit", {255'b0, fill_done}, 256'd1);
      tick();
      wr_en = 1'b0;
      #1;
      chk("done_one_cycle", {255'b0, fill_done}, 256'd0);
      chk("busy_after_commit", {255'b0, fill_busy}, 256'd0);
   endtask

   initial begin
      logic [LINE_W-1:0] la, lb, lc, wd;
      rst = 1'b1; wr_en = 0; wr_index = 0; wr_way = 0; wr_mask = 0; wr_data = 0;
      fill_start = 0; fill_index = 0; fill_way = 0; beat_valid = 0; beat_data = 0;
      set_rd(0, 0);
      repeat (2) tick();
      rst = 1'b0;

      for (int w = 0; w < NUM_WAYS; w++)
         for (int s = 0; s < NUM_SETS; s++) begin
            wr_en = 1'b1; wr_index = IDX_W'(s); wr_way = WAY_W'(w);
            wr_mask = '1; wr_data = '1;
            tick();
         end
      wr_en = 1'b0;
      #1;
      chk("preload", rd_data, {LINE_W{1'b1}});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready", {255'b0, beat_ready}, 256'd0);
      chk("rst_busy", {255'b0, fill_busy}, 256'd0);
      chk("rst_done", {255'b0, fill_done}, 256'd0);
      for (int w = 0; w < NUM_WAYS; w++)
         for (int s = 0; s < NUM_SETS; s++) begin
            set_rd(s, w);
            #1;
            chk("rst_entry", rd_data, 256'd0);
         end

      // Basic fill to [5][1]
      la = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      set_rd(5, 1);
      fill_to_commit(5, 1, la, -1, 0, 0);
      finish_commit();
      chk("basic_line", rd_data, la);
      chk("model_basic_line", m_mem[1][5], {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      set_rd(5, 0);
      #1;
      chk("basic_other_way", rd_data, 256'd0);

      // Stalled beats with a spurious start aimed at set 2
      lb = rand_line();
      set_rd(4, 0);
      fill_to_commit(4, 0, lb, 1, 3, 1);
      finish_commit();
      chk("stall_line", rd_data, lb);
      set_rd(2, 0);
      #1;
      chk("stall_no_spurious", rd_data, 256'd0);

      // Masked single-byte write with same-cycle bypass
      set_rd(3, 0);
      wd = rand_line();
      wd[7:0] = 8'hAB;
      wr_en = 1'b1; wr_index = 3'd3; wr_way = 1'b0; wr_mask = 32'h0000_0001; wr_data = wd;
      #1;
      chk("mask_bypass", rd_data, 256'hAB);
      tick();
      wr_en = 1'b0;
      #1;
      chk("mask_stored", rd_data, 256'hAB);
      chk("model_mask", m_mem[0][3], 256'hAB);

      // Commit and direct write to the same entry [6][1]
      lc = rand_line();
      set_rd(6, 1);
      fill_to_commit(6, 1, lc, -1, 0, 0);
      wd = rand_line();
      wd[255:248] = 8'hCD;
      wr_en = 1'b1; wr_index = 3'd6; wr_way = 1'b1; wr_mask = 32'h8000_0000; wr_data = wd;
      #1;
      chk("collide_bypass", rd_data, {8'hCD, lc[247:0]});
      finish_commit();
      chk("collide_stored", rd_data, {8'hCD, lc[247:0]});

      // Commit to [6][0] while a full-line write lands on [6][1]
      lc = rand_line();
      wd = rand_line();
      set_rd(6, 0);
      fill_to_commit(6, 0, lc, -1, 0, 0);
      wr_en = 1'b1; wr_index = 3'd6; wr_way = 1'b1; wr_mask = '1; wr_data = wd;
      finish_commit();
      chk("parallel_fill", rd_data, lc);
      set_rd(6, 1);
      #1;
      chk("parallel_write", rd_data, wd);

      // Reset in the middle of a fill to [7][1]
      la = rand_line();
      set_rd(7, 1);
      fill_start = 1'b1; fill_index = 3'd7; fill_way = 1'b1;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         beat_valid = 1'b1; beat_data = la[k*BEAT_W +: BEAT_W];
         tick();
      end
      beat_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_busy", {255'b0, fill_busy}, 256'd0);
      chk("midrst_entry", rd_data, 256'd0);
      lb = rand_line();
      fill_to_commit(7, 1, lb, -1, 0, 0);
      finish_commit();
      chk("after_rst_fill", rd_data, lb);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         fill_start = ($urandom_range(0, 5) == 0);
         fill_index = IDX_W'($urandom);
         fill_way   = WAY_W'($urandom);
         beat_valid = $urandom_range(0, 1) == 1;
         beat_data  = {$urandom, $urandom};
         wr_en      = ($urandom_range(0, 3) == 0);
         wr_index   = IDX_W'($urandom);
         wr_way     = WAY_W'($urandom);
         wr_mask    = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
         wr_data    = rand_line();
         set_rd($urandom_range(0, NUM_SETS-1), $urandom_range(0, NUM_WAYS-1));
         tick();
      end
      rst = 0; fill_start = 0; beat_valid = 0; wr_en = 0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
